// File: rtl/sprite_read_arbiter_if.sv
// -----------------------------------------------------------------------------
// sprite_read_arbiter_if
// Bundles the signals between the sprite address generators and the frame RAM
// on one side, and the sprite read arbiter on the other.
//
// Signals:
//   req              per-requester read request, held until granted
//   req_addr         packed read addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_lock         per-requester burst-lock request
//   gnt              one-hot grant (combinational)
//   rd_valid         one-hot read-data valid, one cycle after gnt
//   rd_data          palette data for the rd_valid requester
//   ram_read_address address presented to the frame RAM read port
//   ram_data         registered read data coming back from the frame RAM
//
// Modports:
//   master  environment side (requesters plus the RAM data return)
//   slave   the arbiter
// -----------------------------------------------------------------------------
interface sprite_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 5
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic [ADDR_W-1:0]         ram_read_address;
  logic [DATA_W-1:0]         ram_data;

  modport master (
    output req, req_addr, req_lock, ram_data,
    input  gnt, rd_valid, rd_data, ram_read_address
  );

  modport slave (
    input  req, req_addr, req_lock, ram_data,
    output gnt, rd_valid, rd_data, ram_read_address
  );
endinterface

// File: rtl/sprite_read_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_read_arbiter
// Shares the single read port of the sprite frame RAM between NUM_REQ sprite
// draw requesters. One round-robin grant per cycle; the granted address goes
// straight to the RAM and the RAM's registered output is tagged back to the
// winner one cycle later via rd_valid.
//
// Ports:
//   Clk    system clock, all state on posedge
//   Reset  synchronous, active-high reset
//   bus    sprite_read_arbiter_if.slave (req, req_addr, req_lock, gnt,
//          rd_valid, rd_data, ram_read_address, ram_data)
//
// Optional feature (compile-time macro SPRITE_ARB_LOCK_EN):
//   A two-state IDLE/LOCKED FSM lets a winner that raises req_lock keep the
//   port for up to MAX_BURST consecutive grants. Without the macro req_lock is
//   ignored and arbitration is pure round-robin.
// -----------------------------------------------------------------------------
module sprite_read_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 5,
  parameter int MAX_BURST = 4
) (
  input logic                  Clk,
  input logic                  Reset,
  sprite_read_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr_r;
  logic [PTR_W-1:0]   rr_ptr_nxt_s;
  logic [NUM_REQ-1:0] rd_valid_r;
  logic [NUM_REQ-1:0] gnt_s;
  logic [ADDR_W-1:0]  last_addr_r;
  logic [ADDR_W-1:0]  addr_s;
  logic               rr_found_s;
  logic [PTR_W-1:0]   rr_idx_s;
  logic [PTR_W:0]     cand_s;

  // Pointer advance with wrap from NUM_REQ-1 back to 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NUM_REQ - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Round-robin scan: first asserted request at or after rr_ptr, modulo NUM_REQ.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    cand_s     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
      if (cand_s >= (PTR_W+1)'(NUM_REQ)) begin
        cand_s = cand_s - (PTR_W+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!rr_found_s && bus.req[cand_s[PTR_W-1:0]]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = cand_s[PTR_W-1:0];
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

`ifdef SPRITE_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e      state_r;
  lock_state_e      state_nxt_s;
  logic [PTR_W-1:0] owner_r;
  logic [PTR_W-1:0] owner_nxt_s;
  logic [CNT_W-1:0] burst_cnt_r;
  logic [CNT_W-1:0] burst_cnt_nxt_s;
  logic [CNT_W-1:0] burst_inc_s;

  // Grant, address steering and lock FSM next state.
  always_comb begin
    gnt_s           = '0;
    addr_s          = last_addr_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    state_nxt_s     = state_r;
    owner_nxt_s     = owner_r;
    burst_cnt_nxt_s = burst_cnt_r;
    burst_inc_s     = burst_cnt_r + CNT_W'(1);
    if (Reset) begin
      addr_s          = '0;
      state_nxt_s     = ST_IDLE;
      burst_cnt_nxt_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rr_found_s) begin
            gnt_s[rr_idx_s] = 1'b1;
            addr_s          = bus.req_addr[rr_idx_s*ADDR_W +: ADDR_W];
            rr_ptr_nxt_s    = ptr_inc(rr_idx_s);
            // A one-grant burst is already complete, so only lock if room remains.
            if (bus.req_lock[rr_idx_s] && (MAX_BURST > 1)) begin
              state_nxt_s     = ST_LOCKED;
              owner_nxt_s     = rr_idx_s;
              burst_cnt_nxt_s = CNT_W'(1);
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (bus.req[owner_r] && (burst_cnt_r < CNT_W'(MAX_BURST))) begin
            gnt_s[owner_r]  = 1'b1;
            addr_s          = bus.req_addr[owner_r*ADDR_W +: ADDR_W];
            burst_cnt_nxt_s = burst_inc_s;
            // Lock released or burst exhausted: this grant is the last one.
            if (!bus.req_lock[owner_r] || (burst_inc_s >= CNT_W'(MAX_BURST))) begin
              state_nxt_s     = ST_IDLE;
              burst_cnt_nxt_s = '0;
              rr_ptr_nxt_s    = ptr_inc(owner_r);
            end else begin
              state_nxt_s = ST_LOCKED;
            end
          end else begin
            // Owner dropped its request: no grant this cycle, unlock.
            state_nxt_s     = ST_IDLE;
            burst_cnt_nxt_s = '0;
            rr_ptr_nxt_s    = ptr_inc(owner_r);
          end
        end
        default: begin
          state_nxt_s     = ST_IDLE;
          burst_cnt_nxt_s = '0;
        end
      endcase
    end
  end

  // Lock FSM state registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      owner_r     <= '0;
      burst_cnt_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      owner_r     <= owner_nxt_s;
      burst_cnt_r <= burst_cnt_nxt_s;
    end
  end
`else
  // Grant and address steering, pure round-robin.
  always_comb begin
    gnt_s        = '0;
    addr_s       = last_addr_r;
    rr_ptr_nxt_s = rr_ptr_r;
    if (Reset) begin
      addr_s = '0;
    end else if (rr_found_s) begin
      gnt_s[rr_idx_s] = 1'b1;
      addr_s          = bus.req_addr[rr_idx_s*ADDR_W +: ADDR_W];
      rr_ptr_nxt_s    = ptr_inc(rr_idx_s);
    end else begin
      addr_s = last_addr_r;
    end
  end
`endif

  // Pointer, last-address hold register and one-cycle data-return tag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_ptr_r    <= '0;
      rd_valid_r  <= '0;
      last_addr_r <= '0;
    end else begin
      rr_ptr_r    <= rr_ptr_nxt_s;
      rd_valid_r  <= gnt_s;
      last_addr_r <= addr_s;
    end
  end

  assign bus.gnt              = gnt_s;
  assign bus.ram_read_address = addr_s;
  // A read launched just before Reset rises is discarded immediately, not one cycle later.
  assign bus.rd_valid         = Reset ? '0 : rd_valid_r;
  // The RAM output register is the pipeline stage; no extra flop here.
  assign bus.rd_data          = bus.ram_data;

endmodule

// File: tb/tb_sprite_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sprite_read_arbiter
// Directed bench for sprite_read_arbiter with a bench-side RAM, a behavioural
// round-robin model compared every cycle, and literal expectations per phase.
// -----------------------------------------------------------------------------
module tb_sprite_read_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 5;
  localparam int MAX_BURST = 4;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  sprite_read_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_read_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  // Frame RAM with a one-cycle registered read.
  logic [DATA_W-1:0] mem [0:63];
  always @(posedge Clk) bus.ram_data <= mem[bus.ram_read_address[5:0]];

  int n_cmp = 0;
  int n_bad = 0;
  bit model_en = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: pointer as an integer, search from it, remember last grant.
  int                 m_ptr = 0;
  logic [NUM_REQ-1:0] m_prev_gnt = '0;
  logic [ADDR_W-1:0]  m_prev_addr = '0;
  logic [ADDR_W-1:0]  m_last_addr = '0;

  always @(negedge Clk) begin
    int                 win;
    int                 j;
    logic [NUM_REQ-1:0] e_gnt;
    logic [NUM_REQ-1:0] e_rdv;
    logic [ADDR_W-1:0]  e_addr;
    win = -1;
    if (!Reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (m_ptr + k) % NUM_REQ;
        if (win < 0 && bus.req[j]) win = j;
      end
    end
    e_gnt = '0;
    if (win >= 0) e_gnt[win] = 1'b1;
    if (Reset) e_addr = '0;
    else if (win >= 0) e_addr = bus.req_addr[win*ADDR_W +: ADDR_W];
    else e_addr = m_last_addr;
    e_rdv = Reset ? '0 : m_prev_gnt;
    if (model_en) begin
      check("model_gnt", 32'(bus.gnt), 32'(e_gnt));
      check("model_addr", 32'(bus.ram_read_address), 32'(e_addr));
      check("model_rd_valid", 32'(bus.rd_valid), 32'(e_rdv));
      if (e_rdv != '0) check("model_rd_data", 32'(bus.rd_data), 32'(mem[m_prev_addr[5:0]]));
    end
    if (Reset) begin
      m_ptr       = 0;
      m_prev_gnt  = '0;
      m_prev_addr = '0;
      m_last_addr = '0;
    end else begin
      m_prev_gnt  = e_gnt;
      m_prev_addr = e_addr;
      if (win >= 0) begin
        m_ptr       = (win + 1) % NUM_REQ;
        m_last_addr = e_addr;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  int exp_g1 [6] = '{1, 2, 4, 8, 1, 2};
  int exp_d1 [6] = '{0, 1, 2, 3, 4, 1};
  int exp_d2 [5] = '{1, 4, 7, 10, 13};
  logic [3:0] pat [8] = '{4'b0110, 4'b0110, 4'b1001, 4'b0000, 4'b1111, 4'b0101, 4'b0011, 4'b1000};
`ifdef SPRITE_ARB_LOCK_EN
  int exp_lk [6] = '{1, 2, 2, 2, 2, 4};
`endif

  initial begin
    for (int a = 0; a < 64; a++) mem[a] = DATA_W'(a * 3 + 1);
    for (int i = 0; i < NUM_REQ; i++) mem[10 + i] = DATA_W'(i + 1);
    Reset        = 1'b1;
    bus.req      = '1;
    bus.req_lock = '0;
    bus.req_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) bus.req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(10 + i);

    // Reset with all requests high: nothing granted, nothing valid.
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      check("reset_gnt", 32'(bus.gnt), 32'd0);
      check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("reset_addr", 32'(bus.ram_read_address), 32'd0);
      tick();
    end
    Reset = 1'b0;

    // All requesters: rotation 0,1,2,3,0,1 with data one cycle later.
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      check("rot_gnt", 32'(bus.gnt), 32'(exp_g1[c]));
      if (c > 0) begin
        check("rot_rd_valid", 32'(bus.rd_valid), 32'(exp_g1[c-1]));
        check("rot_rd_data", 32'(bus.rd_data), 32'(exp_d1[c]));
      end
      tick();
    end

    // Single requester 2, addresses 0..4, granted every cycle.
    for (int c = 0; c < 6; c++) begin
      if (c < 5) begin
        bus.req = 4'b0100;
        bus.req_addr[2*ADDR_W +: ADDR_W] = ADDR_W'(c);
      end else begin
        bus.req = 4'b0000;
      end
      @(negedge Clk);
      if (c < 5) check("single_gnt", 32'(bus.gnt), 32'd4);
      else begin
        check("single_idle_gnt", 32'(bus.gnt), 32'd0);
        check("single_hold_addr", 32'(bus.ram_read_address), 32'd4);
      end
      if (c > 0) begin
        check("single_rd_valid", 32'(bus.rd_valid), 32'd4);
        check("single_rd_data", 32'(bus.rd_data), 32'(exp_d2[c-1]));
      end
      tick();
    end
    bus.req_addr[2*ADDR_W +: ADDR_W] = ADDR_W'(12);

    // Grant 1, then 1 and 3 together: 3 wins, then 1.
    bus.req = 4'b0010;
    @(negedge Clk);
    check("pair_first", 32'(bus.gnt), 32'd2);
    tick();
    bus.req = 4'b1010;
    @(negedge Clk);
    check("pair_gnt3", 32'(bus.gnt), 32'd8);
    tick();
    @(negedge Clk);
    check("pair_gnt1", 32'(bus.gnt), 32'd2);
    check("pair_rd_data3", 32'(bus.rd_data), 32'd4);
    tick();
    bus.req = 4'b0000;

    // Grant 0, then Reset: in-flight read discarded, pointer back to 0.
    bus.req = 4'b0001;
    @(negedge Clk);
    check("mid_gnt0", 32'(bus.gnt), 32'd1);
    tick();
    Reset   = 1'b1;
    bus.req = 4'b0000;
    @(negedge Clk);
    check("mid_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    check("post_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    tick();
    bus.req = 4'b1111;
    @(negedge Clk);
    check("post_rst_ptr0", 32'(bus.gnt), 32'd1);
    tick();

    // Mixed patterns, including requests that drop before being granted.
    for (int c = 0; c < 8; c++) begin
      bus.req = pat[c];
      tick();
    end
    bus.req = 4'b0000;
    tick();

`ifdef SPRITE_ARB_LOCK_EN
    // Burst lock on requester 1: four grants, then round-robin resumes at 2.
    model_en = 1'b0;
    Reset    = 1'b1;
    tick();
    Reset        = 1'b0;
    bus.req      = 4'b1111;
    bus.req_lock = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      check("lock_gnt", 32'(bus.gnt), 32'(exp_lk[c]));
      tick();
    end
    Reset        = 1'b1;
    bus.req      = 4'b0000;
    bus.req_lock = 4'b0000;
    model_en     = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
